seq_pattern_fsm: RTL and testbench
==================================

# seq_pattern_fsm

Parametrised serial pattern-detector FSM. It watches a qualified single-bit input stream and asserts a Moore match flag when the most recent `PAT_W` accepted bits equal a compile-time pattern. It supports run-time overlap/non-overlap mode and an optional saturating match counter. It sits after the serial input synchroniser, and it is the generalised successor of the fixed three-state detector.

## Interface
Parameters:
- `PAT_W`, 3: pattern length in bits; legal range 2..16.
- `PATTERN`, 3'b101: pattern to match, `PAT_W` bits wide. MSB is the oldest bit, LSB the newest.
- `CNT_W`, 8: match-counter width; legal range 1..32.

Ports:
- `CLK`, in, 1: clock; all state changes on rising edge.
- `RST`, in, 1: reset, asynchronous, active-low.
- `In1`, in, 1: serial data bit.
- `In_vld`, in, 1: `In1` is accepted on a rising edge only when `In_vld`=1.
- `Overlap`, in, 1: 1 = overlapping matches allowed; 0 = non-overlapping.
- `Cnt_clr`, in, 1: synchronous clear of `Match_cnt`.
- `Out1`, out, 1: registered match flag, one-cycle pulse.
- `Match_cnt`, out, `CNT_W`: saturating count of matches.

## Operation
State:
- `hist`: `PAT_W`-bit shift register of accepted bits.
- `fill`: counter 0..`PAT_W`, width clog2(`PAT_W`+1). This is the FSM state: number of valid history bits since reset or since the last non-overlap match.
- States are `FILL_k` (k=0..`PAT_W`-1) and `ARMED` (`fill`=`PAT_W`).

Accepted bit (`In_vld`=1):
- `hist` <= {`hist`[`PAT_W`-2:0], `In1`}.
- `fill` increments, saturating at `PAT_W`.

Match condition:
- The new `hist` equals `PATTERN`.
- The new `fill` equals `PAT_W`.

On a match:
- `Out1` <= 1 for the next cycle.
- If `Overlap`=1, `fill` stays `PAT_W`, so the history is reused.
- If `Overlap`=0, `fill` <= 0, so the next match needs `PAT_W` fresh bits.

Other cycles:
- No accepted bit: `hist` and `fill` hold, and `Out1` <= 0.
- Bits presented with `In_vld`=0 are ignored entirely.

Mode and counter rules:
- `Overlap` is sampled only on accepted bits. A mid-stream change takes effect at the next accepted bit.
- `Match_cnt` increments by 1 per match and saturates at 2^`CNT_W`-1 (no wrap).
- If `Cnt_clr`=1, `Match_cnt` <= 0. Clear has priority over a simultaneous match, so that match is not counted. `Out1` still pulses.

Reset:
- `RST`=0 immediately forces `hist`=0, `fill`=0, `Out1`=0, `Match_cnt`=0, regardless of `CLK`.
- Reset mid-pattern discards partial progress.
- Release is synchronous-safe: the first bit is accepted on the first rising edge with `RST`=1 and `In_vld`=1.

## Timing
- Latency: the last pattern bit is accepted on edge N; `Out1`=1 during cycle N..N+1; `Out1`=0 after edge N+1 unless edge N+1 is also a match.
- With back-to-back valid bits in overlap mode, consecutive matches produce consecutive pulses (e.g. pattern 2'b11 on a run of ones gives `Out1` high continuously from the 2nd bit).
- `Match_cnt` updates on the same edge as `Out1`.
- Outputs are fully registered; no combinational path from inputs to outputs.
- Minimum match spacing: overlap, 1 accepted bit; non-overlap, `PAT_W` accepted bits.

## Configuration
- Macro `SEQ_PATTERN_FSM_COUNT_EN`.
- Defined: `Match_cnt` counter and `Cnt_clr` logic are implemented as above.
- Undefined: no counter flops are synthesised; `Match_cnt` is tied to 0 and `Cnt_clr` is ignored. `Out1` and FSM behaviour are unchanged.

## Test plan
All cases use the defaults, `PAT_W`=3, `PATTERN`=3'b101, with the macro defined unless noted.
- Reset: hold `RST`=0 with random `In1`/`In_vld` -> `Out1`=0, `Match_cnt`=0 throughout. Assert `RST` asynchronously between edges -> outputs clear before the next edge.
- Overlap: `Overlap`=1, `In_vld`=1, bits 1,0,1,0,1 -> `Out1` pulses after the 3rd and 5th edges; `Match_cnt`=2.
- Non-overlap: `Overlap`=0, bits 1,0,1,0,1,0,1 -> pulses after the 3rd and 7th bits only; `Match_cnt`=2.
- Valid gaps: bits 1,(idle, `In1` toggling),0,(idle),1 -> single pulse one cycle after the final accepted bit; idle bits never affect `hist`.
- Counter: `CNT_W`=2, overlap, bits 1,0,1,0,1,0,1,0,1,0,1 (5 matches) -> `Match_cnt` saturates at 3. `Cnt_clr` on the 6th match edge -> `Match_cnt`=0 while `Out1` still pulses. With the macro undefined -> `Match_cnt`=0 always.
- Reset mid-pattern: bits 1,0, then pulse `RST` low, then bits 1 -> no pulse; continuing 0,1 -> pulse.

Source files
------------

// File: rtl/seq_pattern_fsm_if.sv
// ---------------------------------------------------------------------------
// seq_pattern_fsm_if
// Bus between a serial bit source and the seq_pattern_fsm detector.
//
// Handshake: a bit on In1 is transferred on a rising CLK edge only when
// In_vld=1. There is no back-pressure: the detector accepts every valid bit.
// Overlap and Cnt_clr are sideband controls sampled on the same edge.
//
// Signals:
//   In1       master->slave  serial data bit
//   In_vld    master->slave  In1 qualifier
//   Overlap   master->slave  1 = overlapping matches, 0 = non-overlapping
//   Cnt_clr   master->slave  synchronous clear of Match_cnt
//   Out1      slave->master  registered one-cycle match pulse
//   Match_cnt slave->master  saturating match count
//   Fill_dbg  slave->master  FSM fill level (number of valid history bits)
// ---------------------------------------------------------------------------
interface seq_pattern_fsm_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    localparam int FILL_W = $clog2(PAT_W + 1);

    logic              In1;
    logic              In_vld;
    logic              Overlap;
    logic              Cnt_clr;
    logic              Out1;
    logic [CNT_W-1:0]  Match_cnt;
    logic [FILL_W-1:0] Fill_dbg;

    modport master (
        output In1, In_vld, Overlap, Cnt_clr,
        input  Out1, Match_cnt, Fill_dbg
    );

    modport slave (
        input  In1, In_vld, Overlap, Cnt_clr,
        output Out1, Match_cnt, Fill_dbg
    );
endinterface

// File: rtl/seq_pattern_fsm.sv
// ---------------------------------------------------------------------------
// seq_pattern_fsm
// Serial pattern detector. Asserts a Moore match flag (Out1) for one cycle
// after the most recent PAT_W accepted bits equal PATTERN (MSB = oldest bit).
// Supports run-time overlap / non-overlap matching and an optional
// saturating match counter.
//
// Optional feature macro: SEQ_PATTERN_FSM_COUNT_EN
//   defined   : Match_cnt counter and Cnt_clr logic are implemented
//   undefined : Match_cnt tied to 0, Cnt_clr ignored
//
// Ports:
//   CLK     clock, rising edge
//   RST     asynchronous active-low reset
//   io_bus  seq_pattern_fsm_if.slave (In1, In_vld, Overlap, Cnt_clr in;
//           Out1, Match_cnt, Fill_dbg out)
// ---------------------------------------------------------------------------
module seq_pattern_fsm #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    seq_pattern_fsm_if.slave  io_bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // ST_FILL covers FILL_0..FILL_{PAT_W-1}; r_fill carries k.
    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FILL_W-1:0] r_fill;
    logic [FILL_W-1:0] w_fill_nxt;
    logic [PAT_W-1:0]  r_hist;
    logic [PAT_W-1:0]  w_hist_nxt;
    logic [PAT_W-1:0]  w_hist_shift;
    logic              w_match;
    logic              r_out;

    assign w_hist_shift = {r_hist[PAT_W-2:0], io_bus.In1};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_FILL;
            r_fill  <= '0;
            r_hist  <= '0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_hist  <= w_hist_nxt;
            r_out   <= w_match;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_hist_nxt  = r_hist;
        w_match     = 1'b0;
        if (io_bus.In_vld) begin
            w_hist_nxt = w_hist_shift;
            case (r_state)
                ST_FILL: begin
                    if (r_fill == FILL_LAST) begin
                        // This bit completes the history: first match chance.
                        w_fill_nxt  = FILL_FULL;
                        w_state_nxt = ST_ARMED;
                        w_match     = (w_hist_shift == PATTERN);
                    end else begin
                        w_fill_nxt = r_fill + 1'b1;
                    end
                end
                ST_ARMED: begin
                    w_match = (w_hist_shift == PATTERN);
                end
                default: begin
                    w_state_nxt = ST_FILL;
                    w_fill_nxt  = '0;
                end
            endcase
            // Non-overlap: the matched bits are consumed; hist keeps its
            // contents but fill restarts so PAT_W fresh bits are required.
            if (w_match && !io_bus.Overlap) begin
                w_state_nxt = ST_FILL;
                w_fill_nxt  = '0;
            end
        end
    end

    assign io_bus.Out1     = r_out;
    assign io_bus.Fill_dbg = r_fill;

`ifdef SEQ_PATTERN_FSM_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (io_bus.Cnt_clr) begin
            // Clear wins over a simultaneous match.
            r_cnt <= '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign io_bus.Match_cnt = r_cnt;
`else
    assign io_bus.Match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_pattern_fsm.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_fsm
// Self-checking bench for seq_pattern_fsm (PAT_W=3, PATTERN=3'b101).
// Two instances run in lockstep: CNT_W=8 and CNT_W=2 (saturation).
// Reference model: list of accepted bits since the last restart point;
// a match is "at least 3 fresh bits and the newest three read 1,0,1".
// ---------------------------------------------------------------------------
module tb_seq_pattern_fsm;
  logic CLK;
  logic RST;

  seq_pattern_fsm_if #(.PAT_W(3), .CNT_W(8)) bus8 ();
  seq_pattern_fsm_if #(.PAT_W(3), .CNT_W(2)) bus2 ();

  seq_pattern_fsm #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(8)) dut8 (
    .CLK    (CLK),
    .RST    (RST),
    .io_bus (bus8)
  );

  seq_pattern_fsm #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) dut2 (
    .CLK    (CLK),
    .RST    (RST),
    .io_bus (bus2)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  int m_bits[$];
  int m_cnt8 = 0;
  int m_cnt2 = 0;
  logic m_out = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int c);
`ifdef SEQ_PATTERN_FSM_COUNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".out8"},  32'(bus8.Out1), 32'(m_out));
    check({tag, ".out2"},  32'(bus2.Out1), 32'(m_out));
    check({tag, ".cnt8"},  32'(bus8.Match_cnt), 32'(exp_cnt(m_cnt8)));
    check({tag, ".cnt2"},  32'(bus2.Match_cnt), 32'(exp_cnt(m_cnt2)));
    check({tag, ".fill"},  32'(bus8.Fill_dbg), 32'(m_bits.size()));
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_out  = 1'b0;
  endtask

  task automatic drive(input logic in1, input logic vld, input logic ovl, input logic clr);
    bus8.In1 = in1; bus8.In_vld = vld; bus8.Overlap = ovl; bus8.Cnt_clr = clr;
    bus2.In1 = in1; bus2.In_vld = vld; bus2.Overlap = ovl; bus2.Cnt_clr = clr;
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge.
  task automatic step(input string tag, input logic in1, input logic vld,
                      input logic ovl, input logic clr);
    bit match;
    drive(in1, vld, ovl, clr);
    @(posedge CLK);
    match = 1'b0;
    if (vld) begin
      m_bits.push_back(int'(in1));
      if (m_bits.size() > 3) void'(m_bits.pop_front());
      if (m_bits.size() == 3)
        match = (m_bits[0] * 4 + m_bits[1] * 2 + m_bits[2]) == 5;
      if (match && !ovl) m_bits.delete();
    end
    m_out = match;
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (match) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b0;
    model_reset();
    repeat (cycles) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      @(negedge CLK);
      check_all("rst_hold");
    end
    RST = 1'b1;
  endtask

  task automatic run_bits(input string tag, input logic ovl, input int n, input logic [15:0] bits);
    for (int i = n - 1; i >= 0; i--) step(tag, bits[i], 1'b1, ovl, 1'b0);
  endtask

  initial begin
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    check_all("reset");
    do_reset(4);

    // overlap: 1,0,1,0,1 -> pulses after 3rd and 5th bits, count 2
    run_bits("ovl", 1'b1, 5, 16'b10101);
    check("ovl.total", 32'(bus8.Match_cnt), 32'(exp_cnt(2)));
    step("ovl.idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // non-overlap: 1,0,1,0,1,0,1 -> pulses after 3rd and 7th bits
    do_reset(2);
    run_bits("novl", 1'b0, 7, 16'b1010101);
    check("novl.total", 32'(bus8.Match_cnt), 32'(exp_cnt(2)));

    // valid gaps: idle bits toggle but never enter history
    do_reset(2);
    step("gap", 1'b1, 1'b1, 1'b1, 1'b0);
    step("gap", 1'b0, 1'b0, 1'b1, 1'b0);
    step("gap", 1'b1, 1'b0, 1'b1, 1'b0);
    step("gap", 1'b0, 1'b1, 1'b1, 1'b0);
    step("gap", 1'b1, 1'b0, 1'b1, 1'b0);
    step("gap", 1'b1, 1'b1, 1'b1, 1'b0);
    step("gap", 1'b1, 1'b0, 1'b1, 1'b0);

    // counter saturation (CNT_W=2) then clear on the 6th match edge
    do_reset(2);
    run_bits("sat", 1'b1, 11, 16'b10101010101);
    check("sat.cnt2", 32'(bus2.Match_cnt), 32'(exp_cnt(3)));
    step("clr", 1'b0, 1'b1, 1'b1, 1'b0);
    step("clr", 1'b1, 1'b1, 1'b1, 1'b1);
    check("clr.pulse", 32'(bus8.Out1), 32'd1);

    // reset mid-pattern
    do_reset(2);
    run_bits("mid", 1'b1, 2, 16'b10);
    do_reset(1);
    run_bits("mid", 1'b1, 3, 16'b101);

    // asynchronous reset between edges while a pulse is showing
    do_reset(1);
    run_bits("async", 1'b1, 3, 16'b101);
    RST = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge CLK);
    RST = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
